// File: rtl/timestamp_word_assembler_if.sv
// rtl/timestamp_word_assembler_if.sv - bundle of FIFO, timestamp handshake and counter signals
//
// Purpose: groups everything except clock and reset that crosses the
//          timestamp_word_assembler boundary.
// Ports (by modport):
//   master : drives EN, CLR_CNT, FIFO_EMPTY, FIFO_DATA, TS_READY;
//            observes FIFO_READ, TS_VALID, TS_DATA, SEQ_ERR_CNT, FOREIGN_CNT
//   slave  : the assembler's view (directions mirrored)
interface timestamp_word_assembler_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 EN;
  logic                 CLR_CNT;
  logic                 FIFO_EMPTY;
  logic [31:0]          FIFO_DATA;
  logic                 FIFO_READ;
  logic                 TS_VALID;
  logic                 TS_READY;
  logic [63:0]          TS_DATA;
  logic [CNT_WIDTH-1:0] SEQ_ERR_CNT;
  logic [CNT_WIDTH-1:0] FOREIGN_CNT;

  modport master (
    output EN, CLR_CNT, FIFO_EMPTY, FIFO_DATA, TS_READY,
    input  FIFO_READ, TS_VALID, TS_DATA, SEQ_ERR_CNT, FOREIGN_CNT
  );

  modport slave (
    input  EN, CLR_CNT, FIFO_EMPTY, FIFO_DATA, TS_READY,
    output FIFO_READ, TS_VALID, TS_DATA, SEQ_ERR_CNT, FOREIGN_CNT
  );
endinterface

// File: rtl/timestamp_word_assembler.sv
// rtl/timestamp_word_assembler.sv - rebuilds 64-bit timestamps from three-word FIFO records
//
// Purpose: pops 32-bit words from a first-word-fall-through FIFO, keeps only
//          words carrying IDENTIFIER in bits 31:28, checks the 1-2-3 word-type
//          sequence, and presents the assembled 64-bit timestamp on a
//          valid/ready handshake. Foreign words and sequence errors are
//          counted in saturating counters.
// Ports:
//   BUS_CLK : single clock
//   BUS_RST : synchronous active-high reset
//   bus     : timestamp_word_assembler_if.slave (FIFO side, timestamp
//             handshake, counter clear and counter outputs)
module timestamp_word_assembler #(
  parameter logic [3:0] IDENTIFIER = 4'b0001,
  parameter int         CNT_WIDTH  = 8
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST,
  timestamp_word_assembler_if.slave    bus
);

  typedef enum logic [1:0] {EXP_W1, EXP_W2, EXP_W3, OUT} state_t;

  state_t state, state_next;

  logic [23:0]          lo;
  logic [23:0]          mid;
  logic [63:0]          ts_data;
  logic [CNT_WIDTH-1:0] seq_err_cnt;
  logic [CNT_WIDTH-1:0] foreign_cnt;

  logic       rd;
  logic       id_ok;
  logic [3:0] typ;
  logic       hi_zero;
  logic       take;       // consumed word that belongs to us
  logic       inc_foreign;
  logic       inc_seq;
  logic       load_lo;
  logic       load_mid;
  logic       load_ts;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  assign id_ok   = (bus.FIFO_DATA[31:28] == IDENTIFIER);
  assign typ     = bus.FIFO_DATA[27:24];
  assign hi_zero = (bus.FIFO_DATA[23:16] == 8'h00);
  assign take    = rd & id_ok;

  // State register
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state <= EXP_W1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      EXP_W1: begin
        if (take) begin
          state_next = (typ == 4'h1) ? EXP_W2 : EXP_W1;
        end
      end
      EXP_W2: begin
        if (take) begin
          if (typ == 4'h1)      state_next = EXP_W2;
          else if (typ == 4'h2) state_next = EXP_W3;
          else                  state_next = EXP_W1;
        end
      end
      EXP_W3: begin
        if (take) begin
          if (typ == 4'h1)                  state_next = EXP_W2;
          else if (typ == 4'h3 && hi_zero)  state_next = OUT;
          else                              state_next = EXP_W1;
        end
      end
      OUT: begin
        if (bus.TS_READY) state_next = EXP_W1;
      end
      default: state_next = EXP_W1;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    rd          = !BUS_RST && bus.EN && !bus.FIFO_EMPTY && (state != OUT);
    inc_foreign = rd && !id_ok;
    inc_seq     = 1'b0;
    load_lo     = 1'b0;
    load_mid    = 1'b0;
    load_ts     = 1'b0;
    if (take) begin
      // A type-1 word always (re)starts a record, even mid-assembly.
      load_lo = (typ == 4'h1);
      case (state)
        EXP_W1: inc_seq = (typ != 4'h1);
        EXP_W2: begin
          inc_seq  = (typ != 4'h2);
          load_mid = (typ == 4'h2);
        end
        EXP_W3: begin
          load_ts = (typ == 4'h3) && hi_zero;
          inc_seq = !load_ts;
        end
        default: inc_seq = 1'b0;
      endcase
    end
  end

  // Record registers and counters
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lo          <= '0;
      mid         <= '0;
      ts_data     <= '0;
      seq_err_cnt <= '0;
      foreign_cnt <= '0;
    end else begin
      if (load_lo)  lo  <= bus.FIFO_DATA[23:0];
      if (load_mid) mid <= bus.FIFO_DATA[23:0];
      if (load_ts)  ts_data <= {bus.FIFO_DATA[15:0], mid, lo};

      if (bus.CLR_CNT)                          seq_err_cnt <= '0;
      else if (inc_seq && seq_err_cnt != CNT_MAX) seq_err_cnt <= seq_err_cnt + 1'b1;

      if (bus.CLR_CNT)                                foreign_cnt <= '0;
      else if (inc_foreign && foreign_cnt != CNT_MAX) foreign_cnt <= foreign_cnt + 1'b1;
    end
  end

  assign bus.FIFO_READ   = rd;
  assign bus.TS_VALID    = (state == OUT);
  assign bus.TS_DATA     = ts_data;
  assign bus.SEQ_ERR_CNT = seq_err_cnt;
  assign bus.FOREIGN_CNT = foreign_cnt;

endmodule

// File: tb/tb_timestamp_word_assembler.sv
// tb/tb_timestamp_word_assembler.sv - scoreboard testbench for timestamp_word_assembler
module tb_timestamp_word_assembler;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timestamp_word_assembler_if #(.CNT_WIDTH(CW)) bus ();

  timestamp_word_assembler #(.IDENTIFIER(4'b0001), .CNT_WIDTH(CW)) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo_q[$];
  logic [63:0] exp_q[$];
  logic        rd_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void refresh();
    bus.FIFO_EMPTY = (fifo_q.size() == 0);
    bus.FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endfunction

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // FWFT FIFO model: pop whatever the DUT read at this edge
  always @(posedge clk) begin
    rd_seen = bus.FIFO_READ;
    #1;
    if (rd_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Monitor: compare every completed handshake against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.TS_VALID) check("no_read_while_valid", {63'h0, bus.FIFO_READ}, 64'h0);
      if (bus.TS_VALID && bus.TS_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ts actual=%h required=none", bus.TS_DATA);
        end else begin
          check("ts_data", bus.TS_DATA, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      if (fifo_q.size() == 0 && !bus.TS_VALID && exp_q.size() == 0) break;
      tick();
    end
    if (n == 400) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=pending required=idle", name);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.EN      = 1'b0;
    bus.CLR_CNT = 1'b0;
    bus.TS_READY = 1'b1;
    refresh();
    repeat (3) tick();
    check("rst_valid",   {63'h0, bus.TS_VALID}, 64'h0);
    check("rst_data",    bus.TS_DATA, 64'h0);
    check("rst_seq",     {56'h0, bus.SEQ_ERR_CNT}, 64'h0);
    check("rst_foreign", {56'h0, bus.FOREIGN_CNT}, 64'h0);
    rst    = 1'b0;
    bus.EN = 1'b1;
    tick();

    // 1: basic triple
    exp_q.push_back(64'h4321123456ABCDEF);
    push(32'h11ABCDEF); push(32'h12123456); push(32'h13004321);
    wait_idle("t1");
    check("t1_seq",     {56'h0, bus.SEQ_ERR_CNT}, 64'h0);
    check("t1_foreign", {56'h0, bus.FOREIGN_CNT}, 64'h0);

    // 2: backpressure with a second record queued behind
    bus.TS_READY = 1'b0;
    exp_q.push_back(64'h4321123456ABCDEF);
    exp_q.push_back(64'h0333000222000111);
    push(32'h11ABCDEF); push(32'h12123456); push(32'h13004321);
    push(32'h11000111); push(32'h12000222); push(32'h13000333);
    for (int i = 0; i < 50 && !bus.TS_VALID; i++) tick();
    check("t2_valid_rise", {63'h0, bus.TS_VALID}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_held", {63'h0, bus.TS_VALID}, 64'h1);
      check("t2_data_stable", bus.TS_DATA, 64'h4321123456ABCDEF);
      check("t2_pending", fifo_q.size(), 64'd3);
      tick();
    end
    bus.TS_READY = 1'b1;
    wait_idle("t2");

    // 3: foreign word between word 1 and word 2
    exp_q.push_back(64'h4321123456ABCDEF);
    push(32'h11ABCDEF); push(32'h21FFFFFF); push(32'h12123456); push(32'h13004321);
    wait_idle("t3");
    check("t3_foreign", {56'h0, bus.FOREIGN_CNT}, 64'h1);
    check("t3_seq",     {56'h0, bus.SEQ_ERR_CNT}, 64'h0);

    // 4: restart on repeated word 1, then bad reserved bits on word 3
    exp_q.push_back(64'h0004000003000002);
    push(32'h11000001); push(32'h11000002); push(32'h12000003); push(32'h13000004);
    wait_idle("t4a");
    check("t4_seq1", {56'h0, bus.SEQ_ERR_CNT}, 64'h1);
    push(32'h11000005); push(32'h12000006); push(32'h13010000);
    wait_idle("t4b");
    check("t4_seq2",     {56'h0, bus.SEQ_ERR_CNT}, 64'h2);
    check("t4_data_kept", bus.TS_DATA, 64'h0004000003000002);

    // 5: foreign counter saturation and clear priority
    for (int i = 0; i < 300; i++) push(32'h25000000 | i);
    wait_idle("t5");
    check("t5_sat", {56'h0, bus.FOREIGN_CNT}, 64'hFF);
    push(32'h2F000000);
    bus.CLR_CNT = 1'b1;
    tick();
    bus.CLR_CNT = 1'b0;
    check("t5_clr_foreign", {56'h0, bus.FOREIGN_CNT}, 64'h0);
    check("t5_clr_seq",     {56'h0, bus.SEQ_ERR_CNT}, 64'h0);
    check("t5_fifo_drained", fifo_q.size(), 64'd0);

    // 6: reset mid-record
    push(32'h11000AAA); push(32'h12000BBB);
    repeat (3) tick();
    rst = 1'b1;
    push(32'h11000CCC); push(32'h12000DDD); push(32'h13000EEE);
    tick();
    check("t6_read_in_rst", {63'h0, bus.FIFO_READ}, 64'h0);
    tick();
    check("t6_read_in_rst2", {63'h0, bus.FIFO_READ}, 64'h0);
    check("t6_data_rst", bus.TS_DATA, 64'h0);
    rst = 1'b0;
    exp_q.push_back(64'h0EEE000DDD000CCC);
    wait_idle("t6");
    check("t6_seq", {56'h0, bus.SEQ_ERR_CNT}, 64'h0);

    check("scoreboard_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timestamp_word_assembler.md
Name: timestamp_word_assembler

Overview:
- Downstream consumer of the timestamp core's 32-bit FIFO output stream.
- Reads three-word timestamp records (word types 0x1, 0x2, 0x3) for one configured identifier.
- Checks that the word sequence is valid, rebuilds the 64-bit timestamp, and presents it on a valid/ready interface to on-chip logic such as the event builder or trigger correlator.
- Drops words from other identifiers and counts both protocol errors and foreign words.

Parameters:
- IDENTIFIER, 4'b0001, value expected in word bits 31:28.
- CNT_WIDTH, 8, width of the saturating error and foreign-word counters.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  synchronous, active-high reset.
- EN  in  1  enables FIFO reads; when low, FIFO_READ=0 and all state is held.
- CLR_CNT  in  1  single-cycle pulse that clears both counters.
- FIFO_EMPTY  in  1  upstream FIFO empty flag.
- FIFO_DATA  in  32  upstream word, first-word-fall-through: valid whenever FIFO_EMPTY=0.
- FIFO_READ  out  1  pops the upstream word in the same cycle.
- TS_VALID  out  1  assembled timestamp is available.
- TS_READY  in  1  downstream accepts the timestamp.
- TS_DATA  out  64  assembled timestamp.
- SEQ_ERR_CNT  out  CNT_WIDTH  count of sequence/format errors, saturating.
- FOREIGN_CNT  out  CNT_WIDTH  count of dropped foreign-ID words, saturating.

Behaviour:
- Reset (BUS_RST=1 at a clock edge):
  - state=EXP_W1, TS_VALID=0, TS_DATA=0, both counters=0, partial-word registers=0.
  - FIFO_READ=0 while BUS_RST=1.
  - Reset mid-assembly discards the partial record.
- FIFO_READ = !BUS_RST & EN & !FIFO_EMPTY & (state != OUT). It is combinational, and the word is consumed at that clock edge.
- Word fields: id = [31:28], typ = [27:24].
- States: EXP_W1, EXP_W2, EXP_W3, OUT.
- On each consumed word in EXP_*:
  - id != IDENTIFIER: drop the word; FOREIGN_CNT+1; state unchanged.
  - EXP_W1, typ=1: lo <= [23:0]; go to EXP_W2.
  - EXP_W2, typ=2: mid <= [23:0]; go to EXP_W3.
  - EXP_W3, typ=3 and [23:16]==0: TS_DATA <= {[15:0], mid, lo}; TS_VALID <= 1; go to OUT.
  - EXP_W2 or EXP_W3, typ=1: SEQ_ERR_CNT+1; restart the record (lo <= [23:0]); go to EXP_W2.
  - Any other typ, or typ=3 with [23:16]!=0: SEQ_ERR_CNT+1; go to EXP_W1.
- OUT state:
  - TS_VALID=1; TS_DATA is stable; no reads.
  - When TS_READY=1: TS_VALID <= 0 and go to EXP_W1. The next read can occur in the following cycle.
- Handshake latency:
  - TS_VALID rises on the clock edge that consumes word 3.
  - Minimum 4 cycles per timestamp with TS_READY tied high.
- EN=0:
  - Stops reads only.
  - An already-VALID timestamp still completes its handshake.
  - Partial state is kept.
- Counters:
  - Saturate at all-ones; no wrap.
  - CLR_CNT has priority over a simultaneous increment, so the result is 0.
  - If a FOREIGN_CNT increment and a SEQ_ERR_CNT increment are both pending, both are applied. They are independent registers.
- TS_DATA retains its last value after the handshake. It changes only on word-3 acceptance or reset.

Test Plan:
1. Push 0x11ABCDEF, 0x12123456, 0x13004321 with TS_READY=1 -> exactly one TS_VALID pulse, TS_DATA=0x4321123456ABCDEF, both counters 0.
2. Same triple with TS_READY low for 5 cycles after VALID, and more words queued behind it -> TS_VALID held 6 cycles, TS_DATA stable, FIFO_READ=0 throughout, next record assembles correctly.
3. Insert 0x21FFFFFF between word 1 and word 2 -> word dropped, FOREIGN_CNT=1, TS_DATA=0x4321123456ABCDEF, SEQ_ERR_CNT=0.
4. Push 0x11000001, 0x11000002, 0x12000003, 0x13000004 -> SEQ_ERR_CNT=1, TS_DATA=0x0004000003000002. Also push 0x11..., 0x12..., 0x13010000 -> SEQ_ERR_CNT=2 and no VALID.
5. Feed 300 foreign words, with CLR_CNT pulsed in the same cycle as one increment -> FOREIGN_CNT saturates at 255; after CLR_CNT it reads 0, not 1.
6. Assert BUS_RST after word 2, then push a full triple -> no VALID from the stale words, correct TS_DATA from the new triple, FIFO_READ=0 during reset.
